// File: rtl/packet_width_downsizer_if.sv
// Avalon-ST sink/source bundle for packet_width_downsizer.
// asi_in0_empty exists only with PACKET_WIDTH_DOWNSIZER_EMPTY_EN.
interface packet_width_downsizer_if #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int EW    = (RATIO < 2) ? 1 : $clog2(RATIO);

  logic [IN_WIDTH-1:0]  asi_in0_data;
  logic                 asi_in0_valid;
  logic                 asi_in0_startofpacket;
  logic                 asi_in0_endofpacket;
`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
  logic [EW-1:0]        asi_in0_empty;
`endif
  logic                 asi_in0_ready;
  logic [OUT_WIDTH-1:0] aso_out0_data;
  logic                 aso_out0_valid;
  logic                 aso_out0_startofpacket;
  logic                 aso_out0_endofpacket;
  logic                 aso_out0_ready;

  modport slave (
    input  asi_in0_data,
    input  asi_in0_valid,
    input  asi_in0_startofpacket,
    input  asi_in0_endofpacket,
`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
    input  asi_in0_empty,
`endif
    output asi_in0_ready,
    output aso_out0_data,
    output aso_out0_valid,
    output aso_out0_startofpacket,
    output aso_out0_endofpacket,
    input  aso_out0_ready
  );

  modport master (
    output asi_in0_data,
    output asi_in0_valid,
    output asi_in0_startofpacket,
    output asi_in0_endofpacket,
`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
    output asi_in0_empty,
`endif
    input  asi_in0_ready,
    input  aso_out0_data,
    input  aso_out0_valid,
    input  aso_out0_startofpacket,
    input  aso_out0_endofpacket,
    output aso_out0_ready
  );
endinterface

// File: rtl/packet_width_downsizer.sv
// Wide-to-narrow Avalon-ST packet serializer with out-of-packet drop count.
// Define PACKET_WIDTH_DOWNSIZER_EMPTY_EN to honour asi_in0_empty on EOP beats.
module packet_width_downsizer #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clock_clk,
  input  logic                      reset_reset,
  packet_width_downsizer_if.slave   st,
  output logic [15:0]               drop_count
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int EW    = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam logic [EW-1:0] CNT_MAX = EW'(RATIO - 1);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("IN_WIDTH must be a multiple of OUT_WIDTH, ratio >= 2");
    end
  endgenerate

  typedef enum logic {
    OUT_PKT,
    IN_PKT
  } pkt_e;

  pkt_e pkt_q, pkt_d;

  logic [RATIO-1:0][OUT_WIDTH-1:0] hold_data;
  logic          hold_valid;
  logic          hold_sop;
  logic          hold_eop;
  logic [EW-1:0] cnt;
  logic [EW-1:0] last;
  logic [EW-1:0] sel;
  logic          in_ready;
  logic          acc;
  logic          keep;
  logic          drop;
  logic          out_hs;
  logic          last_hs;

`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
  logic [EW-1:0] hold_empty;
  assign last = hold_eop ? (CNT_MAX - hold_empty) : CNT_MAX;
`else
  assign last = CNT_MAX;
`endif

  assign out_hs   = hold_valid && st.aso_out0_ready;
  assign last_hs  = out_hs && (cnt == last);
  assign in_ready = !hold_valid || last_hs;
  assign acc      = st.asi_in0_valid && in_ready;

  // Packet tracking is independent of whether HOLD is occupied.
  always_comb begin
    pkt_d = pkt_q;
    keep  = 1'b0;
    drop  = 1'b0;
    if (acc) begin
      unique case (1'b1)
        st.asi_in0_startofpacket,
        (pkt_q == IN_PKT): begin
          keep  = 1'b1;
          pkt_d = st.asi_in0_endofpacket ? OUT_PKT : IN_PKT;
        end
        default: drop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) pkt_q <= OUT_PKT;
    else             pkt_q <= pkt_d;
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_sop   <= 1'b0;
      hold_eop   <= 1'b0;
`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
      hold_empty <= '0;
`endif
      cnt        <= '0;
      drop_count <= '0;
    end else begin
      if (keep) begin
        hold_data  <= st.asi_in0_data;
        hold_valid <= 1'b1;
        hold_sop   <= st.asi_in0_startofpacket;
        hold_eop   <= st.asi_in0_endofpacket;
`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
        hold_empty <= st.asi_in0_endofpacket ? st.asi_in0_empty : '0;
`endif
        cnt        <= '0;
      end else if (last_hs) begin
        hold_valid <= 1'b0;
        cnt        <= '0;
      end else if (out_hs) begin
        cnt <= cnt + EW'(1);
      end
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  assign sel = MSB_FIRST ? (CNT_MAX - cnt) : cnt;

  assign st.asi_in0_ready          = in_ready;
  assign st.aso_out0_valid         = hold_valid;
  assign st.aso_out0_data          = hold_data[sel];
  assign st.aso_out0_startofpacket = hold_valid && hold_sop && (cnt == '0);
  assign st.aso_out0_endofpacket   = hold_valid && hold_eop && (cnt == last);
endmodule

// File: tb/tb_packet_width_downsizer.sv
// Self-checking bench for packet_width_downsizer: directed table,
// multi-cycle sequences and randomized traffic against a packet model.
module tb_packet_width_downsizer;
  localparam int IW  = 256;
  localparam int OW  = 32;
  localparam int R   = IW / OW;
  localparam int EW  = $clog2(R);
  localparam bit MSB = 1'b1;

  logic        clock_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [15:0] drop_count;

  packet_width_downsizer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) st ();

  packet_width_downsizer #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .MSB_FIRST(MSB)
  ) dut (
    .clock_clk  (clock_clk),
    .reset_reset(reset_reset),
    .st         (st),
    .drop_count (drop_count)
  );

  always #5 clock_clk = ~clock_clk;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          s;
    logic          e;
  } sl_t;

  typedef struct packed {
    logic          rdy;
    logic          v;
    logic          s;
    logic          e;
    logic          ir;
    logic [OW-1:0] d;
  } row_t;

  sl_t         q[$];
  sl_t         x;
  bit          in_pkt;
  int unsigned mdrops;
  int          errors = 0;
  int          checks = 0;
  int          run, max_run, rdy_hits, vcyc;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a kept beat becomes a list of slices, the rest are drops.
  function automatic void model_accept(logic [IW-1:0] d, logic s,
                                       logic e, int emp);
    int n;
    logic [IW-1:0] sh;
    sl_t t;
    if (s || in_pkt) begin
      n = R;
      if (e) n = R - emp;
      for (int k = 0; k < n; k++) begin
        sh  = MSB ? (d >> (IW - OW * (k + 1))) : (d >> (OW * k));
        t.d = sh[OW-1:0];
        t.s = s && (k == 0);
        t.e = e && (k == n - 1);
        q.push_back(t);
      end
      in_pkt = !e;
    end else if (mdrops != 32'hFFFF) begin
      mdrops++;
    end
  endfunction

  function automatic logic [IW-1:0] rnd_beat();
    logic [IW-1:0] r;
    for (int i = 0; i < IW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clock_clk) begin
    if (reset_reset) begin
      q.delete();
      in_pkt = 1'b0;
      mdrops = 0;
      run    = 0;
    end else begin
      if (st.aso_out0_valid) begin
        run++;
        vcyc++;
        if (run > max_run) max_run = run;
        if (st.asi_in0_ready) rdy_hits++;
      end else begin
        run = 0;
      end
      if (st.aso_out0_valid && st.aso_out0_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none",
                   st.aso_out0_data);
        end else begin
          x = q.pop_front();
          chk("slice",
              {st.aso_out0_startofpacket, st.aso_out0_endofpacket,
               st.aso_out0_data},
              {x.s, x.e, x.d});
        end
      end
      if (st.asi_in0_valid && st.asi_in0_ready) begin
`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
        model_accept(st.asi_in0_data, st.asi_in0_startofpacket,
                     st.asi_in0_endofpacket, int'(st.asi_in0_empty));
`else
        model_accept(st.asi_in0_data, st.asi_in0_startofpacket,
                     st.asi_in0_endofpacket, 0);
`endif
      end
    end
  end

  task automatic drive(logic v, logic [IW-1:0] d, logic s, logic e,
                       int emp);
    st.asi_in0_valid         = v;
    st.asi_in0_data          = d;
    st.asi_in0_startofpacket = s;
    st.asi_in0_endofpacket   = e;
`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
    st.asi_in0_empty         = EW'(emp);
`endif
  endtask

  // Returns the number of sampled cycles the beat waited for ready.
  task automatic send(logic [IW-1:0] d, logic s, logic e, int emp,
                      output int waits);
    int n = 0;
    @(posedge clock_clk);
    #1;
    drive(1'b1, d, s, e, emp);
    @(negedge clock_clk);
    while (!st.asi_in0_ready) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no ready expected ready");
        break;
      end
      @(negedge clock_clk);
    end
    waits = n;
  endtask

  task automatic go_idle();
    @(posedge clock_clk);
    #1;
    drive(1'b0, rnd_beat(), 1'($urandom), 1'($urandom), int'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t          tab[11];
    logic [IW-1:0] b;
    int            w;
    bit            pend;

    tab[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
    tab[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
    tab[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
    tab[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
    tab[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
    tab[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4};
    tab[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5};
    tab[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6};
    tab[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7};
    tab[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd8};
    tab[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};

    drive(1'b0, '0, 1'b0, 1'b0, 0);
    st.aso_out0_ready = 1'b0;
    run = 0; max_run = 0; rdy_hits = 0; vcyc = 0;

    repeat (3) @(posedge clock_clk);
    #1;
    chk("rst_valid_during", st.aso_out0_valid, 1'b0);
    chk("rst_data_during", st.aso_out0_data, 32'd0);
    #3 reset_reset = 1'b0;
    @(negedge clock_clk);
    chk("rst_valid", st.aso_out0_valid, 1'b0);
    chk("rst_sop_eop",
        {st.aso_out0_startofpacket, st.aso_out0_endofpacket}, 2'b00);
    chk("rst_data", st.aso_out0_data, 32'd0);
    chk("rst_in_ready", st.asi_in0_ready, 1'b1);
    chk("rst_drop_count", drop_count, 16'd0);

    // Single SOP+EOP beat with a 1,0,0,1 ready stall mid-beat.
    b = '0;
    for (int k = 0; k < R; k++) b[IW-1-OW*k -: OW] = OW'(k + 1);
    st.aso_out0_ready = 1'b1;
    send(b, 1'b1, 1'b1, 0, w);
    for (int i = 0; i < 11; i++) begin
      @(posedge clock_clk);
      #1;
      if (i == 0) drive(1'b0, '0, 1'b0, 1'b0, 0);
      st.aso_out0_ready = tab[i].rdy;
      @(negedge clock_clk);
      chk($sformatf("table_row%0d", i),
          {st.aso_out0_valid, st.aso_out0_startofpacket,
           st.aso_out0_endofpacket, st.asi_in0_ready,
           st.aso_out0_valid ? st.aso_out0_data : 32'd0},
          {tab[i].v, tab[i].s, tab[i].e, tab[i].ir,
           tab[i].v ? tab[i].d : 32'd0});
    end

    // Three back-to-back beats with the sink always ready.
    @(posedge clock_clk);
    #1;
    max_run = 0; rdy_hits = 0; vcyc = 0;
    send(rnd_beat(), 1'b1, 1'b0, 0, w);
    send(rnd_beat(), 1'b0, 1'b0, 0, w);
    chk("b2b_wait_b", w, R - 1);
    send(rnd_beat(), 1'b0, 1'b1, 0, w);
    chk("b2b_wait_c", w, R - 1);
    go_idle();
    repeat (3 * R + 2) @(negedge clock_clk);
    chk("b2b_run", max_run, 3 * R);
    chk("b2b_valid_cycles", vcyc, 3 * R);
    chk("b2b_ready_pulses", rdy_hits, 3);

    // Out-of-packet beats are discarded and counted.
    @(posedge clock_clk);
    #1;
    vcyc = 0;
    send(rnd_beat(), 1'b0, 1'b0, 0, w);
    send(rnd_beat(), 1'b0, 1'b1, 0, w);
    go_idle();
    repeat (3) @(negedge clock_clk);
    chk("drop_count_two", drop_count, 16'd2);
    chk("drop_model", drop_count, 16'(mdrops));
    chk("drop_no_output", vcyc, 0);

    // Asynchronous reset in the middle of a packet.
    st.aso_out0_ready = 1'b0;
    send(rnd_beat(), 1'b1, 1'b0, 0, w);
    go_idle();
    @(negedge clock_clk);
    chk("pre_rst_valid", st.aso_out0_valid, 1'b1);
    #2 reset_reset = 1'b1;
    #1;
    chk("async_rst_valid", st.aso_out0_valid, 1'b0);
    chk("async_rst_drops", drop_count, 16'd0);
    vcyc = 0;
    repeat (2) @(negedge clock_clk);
    #2 reset_reset = 1'b0;
    st.aso_out0_ready = 1'b1;
    #1;
    chk("post_rst_ready", st.asi_in0_ready, 1'b1);
    send(rnd_beat(), 1'b0, 1'b1, 0, w);
    go_idle();
    repeat (3) @(negedge clock_clk);
    chk("post_rst_drop", drop_count, 16'd1);
    chk("post_rst_no_output", vcyc, 0);

`ifdef PACKET_WIDTH_DOWNSIZER_EMPTY_EN
    // EOP beat with empty=3, then empty ignored on a non-EOP beat.
    send(b, 1'b1, 1'b1, 3, w);
    send(rnd_beat(), 1'b1, 1'b0, 5, w);
    chk("empty_next_accept", w, R - 3 - 1);
    send(rnd_beat(), 1'b0, 1'b1, 0, w);
    chk("empty_ignored_non_eop", w, R - 1);
    go_idle();
    repeat (R + 2) @(negedge clock_clk);
    chk("empty_drain", q.size(), 0);
`endif

    // Randomized traffic with random backpressure.
    pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock_clk);
      #1;
      if (!pend) begin
        if ($urandom_range(0, 2) != 0) begin
          drive(1'b1, rnd_beat(), $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, int'($urandom_range(0, R - 1)));
          pend = 1'b1;
        end else begin
          drive(1'b0, rnd_beat(), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, R - 1)));
        end
      end
      st.aso_out0_ready = $urandom_range(0, 3) != 0;
      @(negedge clock_clk);
      if (st.asi_in0_valid && st.asi_in0_ready) pend = 1'b0;
    end
    go_idle();
    st.aso_out0_ready = 1'b1;
    repeat (2 * R + 4) @(negedge clock_clk);
    chk("rand_drain", q.size(), 0);
    chk("rand_drops", drop_count, 16'(mdrops));
    chk("rand_idle_valid", st.aso_out0_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/packet_width_downsizer.md
PACKET_WIDTH_DOWNSIZER -- requirements
Module: packet_width_downsizer

Interface
REQ-001 Parameter IN_WIDTH, default 256, input beat width in bits.
REQ-002 Parameter OUT_WIDTH, default 32, output symbol width in bits; RATIO = IN_WIDTH/OUT_WIDTH, EW = clog2(RATIO).
REQ-003 Parameter MSB_FIRST, default 1; 1 = first output slice is IN bits [IN_WIDTH-1 -: OUT_WIDTH], 0 = first slice is bits [OUT_WIDTH-1:0].
REQ-004 clock_clk  in  1  clock; all logic on rising edge.
REQ-005 reset_reset  in  1  reset, asynchronous, active-high.
REQ-006 asi_in0_data  in  IN_WIDTH  wide input beat.
REQ-007 asi_in0_valid / asi_in0_startofpacket / asi_in0_endofpacket  in  1 each  Avalon-ST sink qualifiers.
REQ-008 asi_in0_empty  in  EW  unused output slices in EOP beat (present only with macro, REQ-030).
REQ-009 asi_in0_ready  out  1  sink ready, ready latency 0.
REQ-010 aso_out0_data  out  OUT_WIDTH  narrow output symbol.
REQ-011 aso_out0_valid / aso_out0_startofpacket / aso_out0_endofpacket  out  1 each  source qualifiers.
REQ-012 aso_out0_ready  in  1  source ready, ready latency 0.
REQ-013 drop_count  out  16  saturating count of discarded out-of-packet beats.

Function
REQ-014 IN_WIDTH not a multiple of OUT_WIDTH, or RATIO < 2, SHALL fail elaboration.
REQ-015 Holding register (HOLD) stores one accepted beat plus its SOP/EOP/empty; slice counter CNT (EW bits) selects the current slice.
REQ-016 States: IDLE (HOLD empty), OUT_PKT (outside packet), IN_PKT (inside packet); packet state tracked separately from HOLD occupancy.
REQ-017 asi_in0_ready = !hold_valid OR (aso_out0_valid AND aso_out0_ready AND CNT == LAST), combinational; LAST = RATIO-1, or RATIO-1-empty on EOP beat with macro.
REQ-018 Beat accepted on valid AND ready; loads HOLD, CNT <= 0; first slice visible on aso_out0_data the following cycle (latency 1).
REQ-019 Back-to-back beats SHALL sustain one output slice per cycle with no bubble while aso_out0_ready is high.
REQ-020 aso_out0_valid = hold_valid; while valid and not ready, data, SOP, EOP SHALL hold stable.
REQ-021 CNT increments on each output handshake; at LAST handshake HOLD empties unless a new beat is accepted in the same cycle.
REQ-022 aso_out0_startofpacket high only on slice 0 of an SOP beat; aso_out0_endofpacket high only on slice LAST of an EOP beat; SOP+EOP single-beat packet SHALL produce both.
REQ-023 Beat accepted while OUT_PKT without SOP SHALL be consumed and discarded; drop_count +1, saturating at 16'hFFFF.
REQ-024 SOP accepted while IN_PKT SHALL start a new packet; the prior packet is closed without EOP (no synthetic EOP).
REQ-025 Input qualifiers while asi_in0_valid low SHALL be ignored.

Reset
REQ-026 Reset SHALL clear HOLD, CNT, packet state to OUT_PKT, drop_count to 0.
REQ-027 During and after reset: aso_out0_valid/SOP/EOP = 0, aso_out0_data = 0, asi_in0_ready = 1 once reset deasserts.
REQ-028 Reset mid-packet SHALL discard the partial packet; no EOP emitted afterward.
REQ-029 Reset assertion SHALL take effect without a clock edge.

Configuration
REQ-030 Macro PACKET_WIDTH_DOWNSIZER_EMPTY_EN: defined -> asi_in0_empty port exists, EOP beat emits RATIO-empty slices; undefined -> no port, every beat emits RATIO slices.
REQ-031 With macro, empty on a non-EOP beat SHALL be ignored.

Verification
REQ-032 IN=256, OUT=32, MSB_FIRST=1, one SOP+EOP beat 0x0000_0001_..._0000_0008 -> 8 slices 1..8, SOP on slice 1, EOP on slice 8, cycles 1-8 after accept.
REQ-033 Three back-to-back beats, aso_out0_ready held high -> 24 contiguous valid cycles, asi_in0_ready pulses only on slice-8 cycles.
REQ-034 aso_out0_ready toggled 1,0,0,1 mid-beat -> data/valid unchanged during stall, no slice lost or duplicated.
REQ-035 Macro defined, EOP beat empty=3 -> 5 slices, EOP on 5th, next SOP beat accepted same cycle.
REQ-036 Two non-SOP beats while idle -> no output, drop_count = 2; reset pulse mid-packet -> valid 0 immediately, drop_count = 0.
